// File: rtl/par2ser_pkg.sv
// Shared types and helpers for the parallel-to-serial transmitter.
// Optional parity support is controlled by the PAR2SER_PARITY_EN macro.
package par2ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
`ifdef PAR2SER_PARITY_EN
        ,
        PAR   = 2'd2
`endif
    } state_t;

    // Width needed to count 0..value-1; never less than one bit.
    function automatic int clogb2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        for (int i = 0; i < 32; i++) begin
            if ((v >> i) != 0) begin
                result = i + 1;
            end
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/par2ser_shreg.sv
// Load/shift register; the serial output is whichever end bit the captured
// direction selects (MSB when i_dir=1, LSB when i_dir=0).
module par2ser_shreg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic             i_dir,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ser
);

    logic [WIDTH-1:0] r_data;
    logic             r_dir;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_dir  <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_dir  <= i_dir;
        end else if (i_shift) begin
            if (r_dir) begin
                r_data <= {r_data[WIDTH-2:0], 1'b0};
            end else begin
                r_data <= {1'b0, r_data[WIDTH-1:1]};
            end
        end
    end

    assign o_ser = r_dir ? r_data[WIDTH-1] : r_data[0];

endmodule

// File: rtl/par2ser_tx.sv
// Parallel-to-serial transmitter: FSM, bit counter and valid/ready handshake.
// Define PAR2SER_PARITY_EN to append an even-parity bit to every frame.
module par2ser_tx
    import par2ser_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             msb_first,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int             CW   = clogb2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic            r_rdy_en;
    logic            w_accept;
    logic            w_last_data;
    logic            w_shreg_ser;

    // Handshake: a word transfers on any rising edge with data_valid && data_ready.
    // data_ready is high in IDLE (once out of reset) and on the last bit of a frame.
    assign w_last_data = (r_state == SHIFT) && (r_cnt == LAST);
    assign data_ready  = (r_state == IDLE) ? r_rdy_en : frame_end;
    assign w_accept    = data_valid && data_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = SHIFT;
            end
            SHIFT: begin
                if (w_last_data) begin
`ifdef PAR2SER_PARITY_EN
                    w_next = PAR;
`else
                    w_next = w_accept ? SHIFT : IDLE;
`endif
                end
            end
`ifdef PAR2SER_PARITY_EN
            PAR: begin
                w_next = w_accept ? SHIFT : IDLE;
            end
`endif
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (r_state == SHIFT) begin
            r_cnt <= w_last_data ? '0 : r_cnt + 1'b1;
        end
    end

    // Holds data_ready low through reset and raises it on the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
        end
    end

    par2ser_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_shift (r_state == SHIFT),
        .i_dir   (msb_first),
        .i_data  (data_in),
        .o_ser   (w_shreg_ser)
    );

`ifdef PAR2SER_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^data_in;
        end
    end

    assign frame_end = (r_state == PAR);
    assign ser_out   = (r_state == SHIFT) ? w_shreg_ser :
                       (r_state == PAR)   ? r_parity    : 1'b0;
`else
    assign frame_end = w_last_data;
    assign ser_out   = (r_state == SHIFT) ? w_shreg_ser : 1'b0;
`endif

    assign frame_start = (r_state == SHIFT) && (r_cnt == '0);
    assign ser_valid   = (r_state != IDLE);
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_par2ser_tx.sv
// Directed self-checking bench for par2ser_tx at WIDTH=4.
// Parity frames are exercised when PAR2SER_PARITY_EN is defined.
module tb_par2ser_tx;

    logic       clk;
    logic       rst;
    logic [3:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       msb_first;
    logic       ser_out;
    logic       ser_valid;
    logic       frame_start;
    logic       frame_end;
    logic       busy;

    int   checks;
    int   errors;
    logic exp_q[$];

    par2ser_tx #(
        .WIDTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .msb_first   (msb_first),
        .ser_out     (ser_out),
        .ser_valid   (ser_valid),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Outputs as {ser_valid, frame_start, frame_end, data_ready, busy}
    task automatic test_reset();
        logic [5:0] obs;
        rst        = 1'b1;
        data_in    = '0;
        data_valid = 1'b0;
        msb_first  = 1'b0;
        #2;
        obs = {ser_out, ser_valid, frame_start, frame_end, busy, data_ready};
        checks++;
        if (obs !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b exp %b", obs, 6'b0);
        end
        @(negedge clk);
        checks++;
        if (data_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_held: got %b exp 0", data_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (data_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_before_edge: got %b exp 0", data_ready);
        end
        @(negedge clk);
        checks++;
        if ({data_ready, busy, ser_valid} !== 3'b100) begin
            errors++;
            $display("FAIL reset_ready_after_edge: got %b exp 100", {data_ready, busy, ser_valid});
        end
    endtask

    task automatic test_msb_first();
        logic       exp_bit;
        logic [4:0] obs;
        logic [4:0] exp_ctl;
        exp_q = '{1'b1, 1'b0, 1'b1, 1'b1};
        @(negedge clk);
        data_in = 4'b1011; msb_first = 1'b1; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0; data_in = 4'b0000;
        for (int i = 1; i <= 4; i++) begin
            exp_bit = exp_q.pop_front();
            checks++;
            if (ser_out !== exp_bit) begin
                errors++;
                $display("FAIL msb_ser_out cycle %0d: got %b exp %b", i, ser_out, exp_bit);
            end
            obs     = {ser_valid, frame_start, frame_end, data_ready, busy};
            exp_ctl = {1'b1, i == 1, i == 4, i == 4, 1'b1};
            checks++;
            if (obs !== exp_ctl) begin
                errors++;
                $display("FAIL msb_ctl cycle %0d: got %b exp %b", i, obs, exp_ctl);
            end
            @(negedge clk);
        end
        obs = {ser_valid, frame_start, frame_end, data_ready, busy};
        checks++;
        if ({obs, ser_out} !== 6'b000100) begin
            errors++;
            $display("FAIL msb_return_idle: got %b exp 000100", {obs, ser_out});
        end
    endtask

    task automatic test_lsb_toggle();
        logic       exp_bit;
        logic [4:0] obs;
        logic [4:0] exp_ctl;
        exp_q = '{1'b1, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        data_in = 4'b1011; msb_first = 1'b0; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0; data_in = 4'b0000;
        for (int i = 1; i <= 4; i++) begin
            exp_bit = exp_q.pop_front();
            checks++;
            if (ser_out !== exp_bit) begin
                errors++;
                $display("FAIL lsb_ser_out cycle %0d: got %b exp %b", i, ser_out, exp_bit);
            end
            obs     = {ser_valid, frame_start, frame_end, data_ready, busy};
            exp_ctl = {1'b1, i == 1, i == 4, i == 4, 1'b1};
            checks++;
            if (obs !== exp_ctl) begin
                errors++;
                $display("FAIL lsb_ctl cycle %0d: got %b exp %b", i, obs, exp_ctl);
            end
            if (i == 2) msb_first = 1'b1;
            @(negedge clk);
        end
        checks++;
        if ({busy, ser_valid, data_ready} !== 3'b001) begin
            errors++;
            $display("FAIL lsb_return_idle: got %b exp 001", {busy, ser_valid, data_ready});
        end
    endtask

    task automatic test_back_to_back();
        logic       exp_bit;
        logic [4:0] obs;
        logic [4:0] exp_ctl;
        exp_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        data_in = 4'hA; msb_first = 1'b1; data_valid = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 8; i++) begin
            exp_bit = exp_q.pop_front();
            checks++;
            if (ser_out !== exp_bit) begin
                errors++;
                $display("FAIL b2b_ser_out cycle %0d: got %b exp %b", i, ser_out, exp_bit);
            end
            obs     = {ser_valid, frame_start, frame_end, data_ready, busy};
            exp_ctl = {1'b1, (i == 1) || (i == 5), (i == 4) || (i == 8),
                       (i == 4) || (i == 8), 1'b1};
            checks++;
            if (obs !== exp_ctl) begin
                errors++;
                $display("FAIL b2b_ctl cycle %0d: got %b exp %b", i, obs, exp_ctl);
            end
            if (i == 1) data_in = 4'h5;
            if (i == 8) data_valid = 1'b0;
            @(negedge clk);
        end
        checks++;
        if ({busy, ser_valid, data_ready} !== 3'b001) begin
            errors++;
            $display("FAIL b2b_return_idle: got %b exp 001", {busy, ser_valid, data_ready});
        end
    endtask

    task automatic test_reset_mid_frame();
        logic       exp_bit;
        logic [5:0] obs6;
        logic [4:0] obs;
        logic [4:0] exp_ctl;
        @(negedge clk);
        data_in = 4'b1011; msb_first = 1'b1; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        checks++;
        if ({frame_start, ser_valid} !== 2'b11) begin
            errors++;
            $display("FAIL rstmid_started: got %b exp 11", {frame_start, ser_valid});
        end
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        obs6 = {ser_out, ser_valid, frame_start, frame_end, busy, data_ready};
        checks++;
        if (obs6 !== 6'b0) begin
            errors++;
            $display("FAIL rstmid_async_clear: got %b exp 000000", obs6);
        end
        @(negedge clk);
        obs6 = {ser_out, ser_valid, frame_start, frame_end, busy, data_ready};
        checks++;
        if (obs6 !== 6'b0) begin
            errors++;
            $display("FAIL rstmid_held: got %b exp 000000", obs6);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (data_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ready_before_edge: got %b exp 0", data_ready);
        end
        @(negedge clk);
        checks++;
        if ({data_ready, busy, ser_valid} !== 3'b100) begin
            errors++;
            $display("FAIL rstmid_ready_after_edge: got %b exp 100", {data_ready, busy, ser_valid});
        end
        exp_q = '{1'b0, 1'b1, 1'b1, 1'b0};
        data_in = 4'b0110; msb_first = 1'b0; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            exp_bit = exp_q.pop_front();
            checks++;
            if (ser_out !== exp_bit) begin
                errors++;
                $display("FAIL rstmid_next_ser_out cycle %0d: got %b exp %b", i, ser_out, exp_bit);
            end
            obs     = {ser_valid, frame_start, frame_end, data_ready, busy};
            exp_ctl = {1'b1, i == 1, i == 4, i == 4, 1'b1};
            checks++;
            if (obs !== exp_ctl) begin
                errors++;
                $display("FAIL rstmid_next_ctl cycle %0d: got %b exp %b", i, obs, exp_ctl);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_idle();
        data_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            data_in = 4'($urandom_range(0, 15));
            checks++;
            if ({busy, ser_valid, data_ready, ser_out} !== 4'b0010) begin
                errors++;
                $display("FAIL idle cycle %0d: got %b exp 0010", i, {busy, ser_valid, data_ready, ser_out});
            end
        end
    endtask

`ifdef PAR2SER_PARITY_EN
    task automatic test_parity();
        logic       exp_bit;
        logic [4:0] obs;
        logic [4:0] exp_ctl;
        logic [3:0] words [2];
        words[0] = 4'b0111;
        words[1] = 4'b0110;
        exp_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            data_in = words[w]; msb_first = 1'b1; data_valid = 1'b1;
            @(negedge clk);
            data_valid = 1'b0;
            for (int i = 1; i <= 5; i++) begin
                exp_bit = exp_q.pop_front();
                checks++;
                if (ser_out !== exp_bit) begin
                    errors++;
                    $display("FAIL parity_ser_out word %0d cycle %0d: got %b exp %b", w, i, ser_out, exp_bit);
                end
                obs     = {ser_valid, frame_start, frame_end, data_ready, busy};
                exp_ctl = {1'b1, i == 1, i == 5, i == 5, 1'b1};
                checks++;
                if (obs !== exp_ctl) begin
                    errors++;
                    $display("FAIL parity_ctl word %0d cycle %0d: got %b exp %b", w, i, obs, exp_ctl);
                end
                @(negedge clk);
            end
            checks++;
            if ({busy, ser_valid, data_ready} !== 3'b001) begin
                errors++;
                $display("FAIL parity_return_idle word %0d: got %b exp 001", w, {busy, ser_valid, data_ready});
            end
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_idle();
        test_msb_first();
        test_lsb_toggle();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef PAR2SER_PARITY_EN
        test_parity();
`endif
        test_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/par2ser_tx.md
PAR2SER_TX -- requirements
Module: par2ser_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the parallel word width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port data_in, input, WIDTH bits: the parallel word to transmit.
REQ-005 SHALL have port data_valid, input, 1 bit: data_in holds a valid word.
REQ-006 SHALL have port data_ready, output, 1 bit: the block can accept a word this cycle.
REQ-007 SHALL have port msb_first, input, 1 bit: selects bit order, 1 = MSB first, 0 = LSB first.
REQ-008 SHALL have port ser_out, output, 1 bit: the serial data bit.
REQ-009 SHALL have port ser_valid, output, 1 bit: ser_out carries a frame bit.
REQ-010 SHALL have ports frame_start and frame_end, output, 1 bit each: mark the first and last bit of a frame.
REQ-011 SHALL have port busy, output, 1 bit: the block is not in IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and PAR; PAR exists only with the parity macro (REQ-025).
REQ-013 SHALL accept a word on any rising edge where data_valid && data_ready: capture data_in and msb_first, clear the bit counter, and enter SHIFT.
REQ-014 SHALL present the first data bit on the cycle after acceptance (latency 1), with ser_valid=1 and frame_start=1.
REQ-015 SHALL output exactly WIDTH data bits on consecutive cycles: data_in[WIDTH-1] down to [0] when msb_first=1, else [0] up to [WIDTH-1].
REQ-016 SHALL keep msb_first changes during a frame from affecting that frame; the captured value applies.
REQ-017 SHALL use a bit counter of clogb2(WIDTH) bits that wraps to 0 when each frame completes.
REQ-018 SHALL assert frame_end on the last bit of the frame: the last data bit, or the parity bit when parity is enabled.
REQ-019 SHALL drive data_ready=1 in IDLE and on the frame_end cycle, and data_ready=0 otherwise.
REQ-020 SHALL, when a word is accepted on the frame_end cycle, start the next frame on the following cycle with no idle gap (frame_start=1).
REQ-021 SHALL, when no word is accepted at frame_end, return to IDLE, where ser_valid=0, ser_out=0 and busy=0.
REQ-022 SHALL ignore data_valid while data_ready=0; a word that is held stays pending until it is accepted.

Reset
REQ-023 SHALL, while rst=1, force state IDLE, counter 0, shift register 0, ser_out=0, ser_valid=0, frame_start=0, frame_end=0, busy=0 and data_ready=0, regardless of clk.
REQ-024 SHALL abort a frame in progress when reset is asserted mid-frame, with no resumption, and SHALL raise data_ready on the first clk edge after rst deasserts.

Configuration
REQ-025 SHALL, when macro PAR2SER_PARITY_EN is defined, append one even-parity bit (XOR of the WIDTH captured bits) in state PAR after the last data bit, giving frames of WIDTH+1 bits.
REQ-026 SHALL, when PAR2SER_PARITY_EN is undefined, contain no PAR state and no parity logic, giving frames of WIDTH bits.

Structure
REQ-027 SHALL take the FSM state typedef (IDLE/SHIFT/PAR) and the clogb2 constant function from shared package par2ser_pkg.
REQ-028 SHALL instantiate one sub-module, par2ser_shreg: a load/shift register with a direction input whose serial output is the selected end bit.
REQ-029 SHALL keep the FSM, counter and handshake logic in par2ser_tx itself.

Verification (WIDTH=4)
REQ-030 SHALL cover: data_in=4'b1011, msb_first=1 -> ser_out 1,0,1,1 on cycles 1-4 after accept; frame_start on cycle 1; frame_end on cycle 4.
REQ-031 SHALL cover: data_in=4'b1011, msb_first=0 -> ser_out 1,1,0,1; msb_first toggled mid-frame does not change the sequence.
REQ-032 SHALL cover: 4'hA then 4'h5 with data_valid held high -> 8 contiguous ser_valid cycles; frame_start on cycles 1 and 5; data_ready high only on cycles 4 and 8.
REQ-033 SHALL cover: rst pulsed on cycle 2 of a frame -> all outputs 0 immediately; data_ready=1 one edge after release; the next frame starts clean.
REQ-034 SHALL cover, with PAR2SER_PARITY_EN: 4'b0111, msb_first=1 -> ser_out 0,1,1,1,1 (parity 1); frame_end on cycle 5; 4'b0110 gives parity bit 0.
REQ-035 SHALL cover: data_valid=0 for 10 cycles -> busy=0, ser_valid=0, data_ready=1 throughout.
